// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive sequencers.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Total bit periods in one frame, start bit through last stop bit.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts oversample ticks and flags the last tick of each bit period.
module uart_bit_timer #(
    parameter int BAUDCLOCK = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic btick,
    output logic bit_end
);
    localparam int CW = $clog2(BAUDCLOCK);
    localparam logic [CW-1:0] LAST = CW'(BAUDCLOCK - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en & btick & (cnt == LAST);

    // Held at zero while disabled so every frame starts counting from acceptance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (btick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: takes a byte by valid/ready and shifts one frame onto TX,
// timed by the externally generated oversample tick.
//
// state    | meaning
// S_IDLE   | line high, ready for a byte
// S_START  | driving start bit (low)
// S_DATA   | driving data bits, LSB first
// S_PARITY | driving odd/even parity bit
// S_STOP   | driving stop bit(s) (high)
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUDCLOCK = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BTICK,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    uart_state_e          state, state_nxt;
    logic [DATA_BITS-1:0] sh, sh_nxt;
    logic [IW-1:0]        bit_idx, bit_idx_nxt;
    logic                 par_acc, par_acc_nxt;
    logic                 tx_q, tx_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic                 bit_end;
    logic                 par_new;

    uart_bit_timer #(
        .BAUDCLOCK (BAUDCLOCK)
    ) u_bit_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .en      (state != S_IDLE),
        .btick   (BTICK),
        .bit_end (bit_end)
    );

    assign par_new  = par_acc ^ sh[0];
    assign TX_READY = (state == S_IDLE);
    assign TX       = tx_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            sh      <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh      <= sh_nxt;
            bit_idx <= bit_idx_nxt;
            par_acc <= par_acc_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // TX is registered, so each branch sets up the level of the bit that follows.
    always_comb begin
        state_nxt   = state;
        sh_nxt      = sh;
        bit_idx_nxt = bit_idx;
        par_acc_nxt = par_acc;
        tx_nxt      = tx_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (TX_VALID) begin
                    sh_nxt      = TX_DATA;
                    par_acc_nxt = 1'b0;
                    bit_idx_nxt = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_nxt    = sh[0];
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    sh_nxt      = sh >> 1;
                    par_acc_nxt = par_new;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_nxt = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_nxt    = (PARITY == PAR_ODD) ? ~par_new : par_new;
                            state_nxt = S_PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = S_STOP;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        tx_nxt      = sh[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_nxt    = 1'b1;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_nxt = '0;
                        done_nxt    = 1'b1;
                        busy_nxt    = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: four parameterisations share stimulus, a tick-counting
// monitor decodes the selected TX line and compares against queued frames.
module tb_uart_tx_ctrl;

    localparam int BAUD = 16;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        bit          exact;
        bit          b2b;
        bit          abort;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       btick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [1:0] sel;
    logic [3:0] valid_v, ready_v, tx_v, busy_v, done_v;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tick_div = 1;
    bit   tick_en  = 1'b1;
    exp_t q[$];
    exp_t cur;
    bit   in_frame = 1'b0;
    bit   rogue    = 1'b0;
    bit   side_bad = 1'b0;
    int   tcnt = 0;
    int   start_cyc = 0;
    int   last_done_cyc = -100;

    assign valid_v = tx_valid ? (4'b0001 << sel) : 4'b0000;

    uart_tx_ctrl #(.BAUDCLOCK(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
        .CLK(clk), .RST_N(rst_n), .BTICK(btick), .TX_DATA(tx_data), .TX_VALID(valid_v[0]),
        .TX_READY(ready_v[0]), .TX(tx_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]));
    uart_tx_ctrl #(.BAUDCLOCK(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .CLK(clk), .RST_N(rst_n), .BTICK(btick), .TX_DATA(tx_data), .TX_VALID(valid_v[1]),
        .TX_READY(ready_v[1]), .TX(tx_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]));
    uart_tx_ctrl #(.BAUDCLOCK(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .CLK(clk), .RST_N(rst_n), .BTICK(btick), .TX_DATA(tx_data), .TX_VALID(valid_v[2]),
        .TX_READY(ready_v[2]), .TX(tx_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]));
    uart_tx_ctrl #(.BAUDCLOCK(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .CLK(clk), .RST_N(rst_n), .BTICK(btick), .TX_DATA(tx_data), .TX_VALID(valid_v[3]),
        .TX_READY(ready_v[3]), .TX(tx_v[3]), .BUSY(busy_v[3]), .DONE(done_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Tick source: every cycle for tick_div=1, else one pulse per tick_div cycles.
    initial begin
        int phase;
        phase = 0;
        btick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!tick_en) begin
                btick = 1'b0;
                phase = 0;
            end else begin
                btick = (phase == 0);
                phase = (phase + 1 >= tick_div) ? 0 : phase + 1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts the ticks the DUT will consume and samples TX at the first,
    // middle and last tick of every bit; DONE must follow the final counted tick.
    initial forever begin
        int k, ph;
        @(negedge clk);
        if (!rst_n) begin
            in_frame = 1'b0;
            rogue    = 1'b0;
        end else begin
            if (rogue && ready_v[sel]) rogue = 1'b0;
            if (!in_frame && !rogue && tx_v[sel] == 1'b0) begin
                if (q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    rogue = 1'b1;
                end else begin
                    cur       = q.pop_front();
                    in_frame  = 1'b1;
                    tcnt      = 0;
                    side_bad  = 1'b0;
                    start_cyc = cyc;
                    if (cur.b2b) check("b2b_gap", cyc - last_done_cyc, 1);
                end
            end
            if (in_frame) begin
                if (tcnt == cur.nbits * BAUD) begin
                    check("frame_end_done", int'(done_v[sel]), 1);
                    check("frame_end_ready_busy", int'({ready_v[sel], busy_v[sel]}), 2);
                    check("frame_ready_low_busy_high", int'(side_bad), 0);
                    if (cur.exact) check("done_latency", cyc - start_cyc, cur.nbits * BAUD);
                    if (cur.abort) check("aborted_frame_completed", 1, 0);
                    last_done_cyc = cyc;
                    in_frame = 1'b0;
                end else begin
                    if (ready_v[sel] || !busy_v[sel] || done_v[sel]) side_bad = 1'b1;
                    if (btick) begin
                        k  = tcnt / BAUD;
                        ph = tcnt % BAUD;
                        if (ph == 0 || ph == BAUD / 2 || ph == BAUD - 1)
                            check($sformatf("tx_bit%0d_tick%0d", k, ph), int'(tx_v[sel]), int'(cur.bits[k]));
                        tcnt++;
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] bits, input int nbits, input bit exact,
                            input bit b2b, input bit abort);
        exp_t e;
        e.bits = bits; e.nbits = nbits; e.exact = exact; e.b2b = b2b; e.abort = abort;
        q.push_back(e);
    endtask

    task automatic handshake(input logic [7:0] d);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (ready_v[sel]) break;
            n++;
        end
        if (n >= 5000) check("handshake_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            if (!in_frame && q.size() == 0) break;
            n++;
        end
        if (n >= 20000) check("idle_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_tcnt(input int t);
        int n;
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            if (in_frame && tcnt >= t) break;
            n++;
        end
        if (n >= 20000) check("tick_wait_timeout", 0, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        sel      = 2'd0;
        #23;
        check("rst_tx", int'(tx_v), 15);
        check("rst_ready", int'(ready_v), 15);
        check("rst_busy", int'(busy_v), 0);
        check("rst_done", int'(done_v), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // 0x55, no parity, one stop
        push_exp({6'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b1, 1'b0, 1'b0);
        handshake(8'h55);
        tx_valid = 1'b0;
        wait_idle();

        // 0x07 even parity -> parity bit 1
        sel = 2'd1;
        push_exp({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1, 1'b0, 1'b0);
        handshake(8'h07);
        tx_valid = 1'b0;
        wait_idle();

        // 0x07 odd parity -> parity bit 0
        sel = 2'd2;
        push_exp({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1, 1'b0, 1'b0);
        handshake(8'h07);
        tx_valid = 1'b0;
        wait_idle();

        // back-to-back 0xA3, 0x3C with two stop bits, valid held high
        sel = 2'd3;
        push_exp({5'b0, 2'b11, 8'hA3, 1'b0}, 11, 1'b1, 1'b0, 1'b0);
        handshake(8'hA3);
        push_exp({5'b0, 2'b11, 8'h3C, 1'b0}, 11, 1'b1, 1'b1, 1'b0);
        handshake(8'h3C);
        tx_valid = 1'b0;
        wait_idle();

        // divided tick with a 200-cycle stall inside data bit 1 (0x4D bit1 = 0)
        sel = 2'd0;
        tick_div = 5;
        push_exp({6'b0, 1'b1, 8'h4D, 1'b0}, 10, 1'b0, 1'b0, 1'b0);
        handshake(8'h4D);
        tx_valid = 1'b0;
        wait_tcnt(2 * BAUD + 5);
        tick_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (40) @(posedge clk);
            #1;
            check("stall_tx", int'(tx_v[0]), 0);
            check("stall_busy", int'(busy_v[0]), 1);
        end
        tick_en = 1'b1;
        wait_idle();
        tick_div = 1;

        // reset at tick 70 of a 0x00 frame, then a clean 0xFF frame
        push_exp({6'b0, 1'b1, 8'h00, 1'b0}, 10, 1'b0, 1'b0, 1'b1);
        handshake(8'h00);
        tx_valid = 1'b0;
        wait_tcnt(70);
        @(posedge clk); #1;
        check("pre_reset_tx", int'(tx_v[0]), 0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx", int'(tx_v[0]), 1);
        check("mid_reset_busy", int'(busy_v[0]), 0);
        check("mid_reset_ready", int'(ready_v[0]), 1);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        push_exp({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 1'b1, 1'b0, 1'b0);
        handshake(8'hFF);
        tx_valid = 1'b0;
        wait_idle();

        // valid pulse with 0x11 while busy must be ignored
        push_exp({6'b0, 1'b1, 8'h96, 1'b0}, 10, 1'b1, 1'b0, 1'b0);
        handshake(8'h96);
        tx_valid = 1'b0;
        wait_tcnt(50);
        @(posedge clk); #1;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        check("busy_ready", int'(ready_v[0]), 0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_idle();
        repeat (300) @(posedge clk);
        #1;
        check("no_extra_frame", int'(in_frame | rogue), 0);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
